// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the datapath (master) and the memory responder (slave).
// Handshake: memRead/memWrite are level requests sampled every cycle once ready=1; readData is combinational in the request cycle.
interface data_memory_responder_if #(
    parameter int N = 64
);
    logic         memRead;
    logic         memWrite;
    logic [N-1:0] address;
    logic [N-1:0] writeData;
    logic [N-1:0] readData;
    logic         ready;
    logic         err_misalign;
    logic         err_range;
    logic [N-1:0] err_addr;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
    logic         state_dbg;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, ready, err_misalign, err_range, err_addr, rd_count, wr_count, state_dbg
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, ready, err_misalign, err_range, err_addr, rd_count, wr_count, state_dbg
    );
endinterface

// File: rtl/data_memory_responder.sv
// Self-initialising data memory: fills every word after reset, then serves single-cycle
// reads/writes, flags illegal addresses and counts accepted accesses.
module data_memory_responder #(
    parameter int N         = 64,
    parameter int DEPTH     = 64,
    parameter int INIT_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    data_memory_responder_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {INIT, READY} state_t;

    state_t          state;
    logic [AW-1:0]   init_ptr;
    logic            ready_q;
    logic            err_misalign_q;
    logic            err_range_q;
    logic [N-1:0]    err_addr_q;
    logic [31:0]     rd_count_q;
    logic [31:0]     wr_count_q;

    logic [N-1:0]    mem [DEPTH];

    logic [AW-1:0]   idx;
    logic [N-1:0]    word_addr;
    logic            misaligned;
    logic            out_of_range;
    logic            legal;
    logic            rd_ok;
    logic            wr_ok;
    logic            any_access;

    logic            mem_we;
    logic [AW-1:0]   mem_widx;
    logic [N-1:0]    mem_wdata;

    assign idx          = bus.address[3 +: AW];
    assign word_addr    = bus.address >> 3;
    assign misaligned   = |bus.address[2:0];
    assign out_of_range = word_addr >= N'(DEPTH);
    assign legal        = !misaligned && !out_of_range;
    assign rd_ok        = !reset && (state == READY) && bus.memRead && legal;
    assign wr_ok        = !reset && (state == READY) && bus.memWrite && legal;
    assign any_access   = (state == READY) && (bus.memRead || bus.memWrite);

    // Single write port shared by the fill sequencer and datapath stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state == INIT) begin
                mem_we    = 1'b1;
                mem_widx  = init_ptr;
                mem_wdata = (INIT_MODE == 1) ? N'(init_ptr) : '0;
            end else if (wr_ok) begin
                mem_we    = 1'b1;
                mem_widx  = idx;
                mem_wdata = bus.writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            init_ptr       <= '0;
            ready_q        <= 1'b0;
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_addr_q     <= '0;
            rd_count_q     <= '0;
            wr_count_q     <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == AW'(DEPTH - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (any_access && !legal) begin
                        if (misaligned)   err_misalign_q <= 1'b1;
                        if (out_of_range) err_range_q    <= 1'b1;
                        // Only the first fault since reset is recorded.
                        if (!err_misalign_q && !err_range_q) err_addr_q <= bus.address;
                    end
                    if (rd_ok && rd_count_q != 32'hFFFF_FFFF) rd_count_q <= rd_count_q + 32'd1;
                    if (wr_ok && wr_count_q != 32'hFFFF_FFFF) wr_count_q <= wr_count_q + 32'd1;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Read port returns the pre-edge word, so a same-cycle write shows up next cycle.
    assign bus.readData     = rd_ok ? mem[idx] : '0;
    assign bus.ready        = ready_q;
    assign bus.err_misalign = err_misalign_q;
    assign bus.err_range    = err_range_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.rd_count     = rd_count_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.state_dbg    = (state == READY);
endmodule
